// File: rtl/cycle_sequencer_if.sv
// Control/status bundle for the cycle sequencer: run controls in, phase strobes and counters out.
interface cycle_sequencer_if #(parameter int RETIRE_W = 16);
  logic                start;
  logic                mem_ready;
  logic                exec_extra;
  logic                halted;
  logic                fetch;
  logic                decode;
  logic                execute;
  logic                instruction_end;
  logic                stopped;
  logic                fault;
  logic [RETIRE_W-1:0] retired;
  logic [2:0]          state;

  modport master (
    output start, mem_ready, exec_extra, halted,
    input  fetch, decode, execute, instruction_end, stopped, fault, retired, state
  );

  modport slave (
    input  start, mem_ready, exec_extra, halted,
    output fetch, decode, execute, instruction_end, stopped, fault, retired, state
  );
endinterface

// File: rtl/cycle_sequencer.sv
// Instruction cycle sequencer: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK loop with
// fetch timeout, terminal HALT and a saturating retired-instruction counter.
module cycle_sequencer #(
  parameter int RETIRE_W   = 16,
  parameter int WAIT_LIMIT = 8
) (
  input logic             clk,
  input logic             rst_n,
  cycle_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam int                    WAIT_W     = $clog2(WAIT_LIMIT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(WAIT_LIMIT - 1);
  localparam logic [RETIRE_W-1:0]   RETIRE_MAX = {RETIRE_W{1'b1}};

  state_t              state_r;
  state_t              state_next_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [WAIT_W-1:0]   wait_cnt_next_s;
  logic                fault_set_s;
  logic                retire_inc_s;
  logic                fault_r;
  logic [RETIRE_W-1:0] retired_r;
  logic                fetch_r;
  logic                decode_r;
  logic                execute_r;
  logic                instruction_end_r;
  logic                stopped_r;

  // Next-state, wait-counter and event decode; halted outranks every other input.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    fault_set_s     = 1'b0;
    retire_inc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.halted) begin
          state_next_s = ST_HALT;
        end else if (bus.start) begin
          state_next_s    = ST_FETCH;
          wait_cnt_next_s = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.halted) begin
          state_next_s = ST_HALT;
        end else if (bus.mem_ready) begin
          // A word arriving on the limit cycle still counts as a successful fetch.
          state_next_s = ST_DECODE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_next_s = ST_HALT;
          fault_set_s  = 1'b1;
        end else begin
          wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        if (bus.halted) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (bus.halted) begin
          state_next_s = ST_HALT;
        end else if (bus.exec_extra) begin
          state_next_s = ST_EXECUTE;
        end else begin
          state_next_s = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        retire_inc_s = 1'b1;
        if (bus.halted) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s    = ST_FETCH;
          wait_cnt_next_s = '0;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s    = ST_IDLE;
        wait_cnt_next_s = '0;
      end
    endcase
  end

  // State, counters and sticky fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      fault_r    <= 1'b0;
      retired_r  <= '0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      fault_r    <= fault_r | fault_set_s;
      if (retire_inc_s && (retired_r != RETIRE_MAX)) begin
        retired_r <= retired_r + RETIRE_W'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Phase strobes registered from the next state so they always match state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_r           <= 1'b0;
      decode_r          <= 1'b0;
      execute_r         <= 1'b0;
      instruction_end_r <= 1'b0;
      stopped_r         <= 1'b0;
    end else begin
      fetch_r           <= (state_next_s == ST_FETCH);
      decode_r          <= (state_next_s == ST_DECODE);
      execute_r         <= (state_next_s == ST_EXECUTE);
      instruction_end_r <= (state_next_s == ST_WRITEBACK);
      stopped_r         <= (state_next_s == ST_HALT);
    end
  end

  assign bus.fetch           = fetch_r;
  assign bus.decode          = decode_r;
  assign bus.execute         = execute_r;
  assign bus.instruction_end = instruction_end_r;
  assign bus.stopped         = stopped_r;
  assign bus.fault           = fault_r;
  assign bus.retired         = retired_r;
  assign bus.state           = state_r;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed self-checking bench for cycle_sequencer: phase sequencing, stalls, timeout,
// halt handling, asynchronous reset and retired-counter saturation.
module tb_cycle_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cycle_sequencer_if #(.RETIRE_W(16)) bus_main ();
  cycle_sequencer_if #(.RETIRE_W(4))  bus_small ();

  cycle_sequencer #(.RETIRE_W(16), .WAIT_LIMIT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_main)
  );

  cycle_sequencer #(.RETIRE_W(4), .WAIT_LIMIT(8)) dut_small (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {bus_main.state, bus_main.fetch, bus_main.decode, bus_main.execute,
                bus_main.instruction_end, bus_main.stopped, bus_main.fault};

  // Expected {state, fetch, decode, execute, instruction_end, stopped, fault}.
  function automatic logic [8:0] exp_vec(input logic [2:0] st, input logic flt);
    return {st, (st == 3'd1), (st == 3'd2), (st == 3'd3), (st == 3'd4), (st == 3'd5), flt};
  endfunction

  task automatic drive(input logic s, input logic mr, input logic ex, input logic h);
    bus_main.start      = s;
    bus_main.mem_ready  = mr;
    bus_main.exec_extra = ex;
    bus_main.halted     = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    bus_small.start = 1'b0; bus_small.mem_ready = 1'b0;
    bus_small.exec_extra = 1'b0; bus_small.halted = 1'b0;
    #1;
    n_cmp++;
    if (obs !== exp_vec(3'd0, 1'b0)) begin
      n_err++; $display("FAIL reset_vec: got %h want %h", obs, exp_vec(3'd0, 1'b0));
    end
    n_cmp++;
    if (bus_main.retired !== 16'd0) begin
      n_err++; $display("FAIL reset_retired: got %0d want 0", bus_main.retired);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_vec(3'd0, 1'b0)) begin
      n_err++; $display("FAIL idle_hold: got %h want %h", obs, exp_vec(3'd0, 1'b0));
    end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec(3'(i % 4 + 1), 1'b0)) begin
        n_err++; $display("FAIL basic_vec[%0d]: got %h want %h", i, obs, exp_vec(3'(i % 4 + 1), 1'b0));
      end
      n_cmp++;
      if (bus_main.retired !== 16'(i / 4)) begin
        n_err++; $display("FAIL basic_retired[%0d]: got %0d want %0d", i, bus_main.retired, i / 4);
      end
    end
  endtask

  task automatic test_stall();
    logic [2:0] st_tab [11];
    st_tab = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd1};
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec(st_tab[k], 1'b0)) begin
        n_err++; $display("FAIL stall_vec[%0d]: got %h want %h", k, obs, exp_vec(st_tab[k], 1'b0));
      end
      n_cmp++;
      if (bus_main.retired !== ((k == 10) ? 16'd1 : 16'd0)) begin
        n_err++; $display("FAIL stall_retired[%0d]: got %0d", k, bus_main.retired);
      end
      drive(1'b1, (k >= 4), (k < 8), 1'b0);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] st;
    // Memory never answers: eight FETCH cycles, then HALT with fault; HALT is terminal.
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      st = (k == 0) ? 3'd0 : ((k <= 8) ? 3'd1 : 3'd5);
      n_cmp++;
      if (obs !== exp_vec(st, (k >= 9))) begin
        n_err++; $display("FAIL timeout_vec[%0d]: got %h want %h", k, obs, exp_vec(st, (k >= 9)));
      end
      drive(1'b1, (k >= 9), (k >= 9), 1'b0);
    end
    n_cmp++;
    if (bus_main.retired !== 16'd0) begin
      n_err++; $display("FAIL timeout_retired: got %0d want 0", bus_main.retired);
    end
    // Word arrives exactly on the eighth FETCH cycle.
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      st = (k == 0) ? 3'd0 : ((k <= 8) ? 3'd1 : 3'd2);
      n_cmp++;
      if (obs !== exp_vec(st, 1'b0)) begin
        n_err++; $display("FAIL limit_ready_vec[%0d]: got %h want %h", k, obs, exp_vec(st, 1'b0));
      end
      drive(1'b1, (k == 8), 1'b0, 1'b0);
    end
    // halted on the timeout cycle: HALT but no fault.
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      st = (k == 0) ? 3'd0 : ((k <= 8) ? 3'd1 : 3'd5);
      n_cmp++;
      if (obs !== exp_vec(st, 1'b0)) begin
        n_err++; $display("FAIL halt_vs_timeout[%0d]: got %h want %h", k, obs, exp_vec(st, 1'b0));
      end
      drive(1'b1, 1'b0, 1'b0, (k == 8));
    end
  endtask

  task automatic test_halt();
    logic [2:0] st_a [6];
    logic [2:0] st_b [7];
    st_a = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd5};
    st_b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec(st_a[k], 1'b0)) begin
        n_err++; $display("FAIL halt_exec_vec[%0d]: got %h want %h", k, obs, exp_vec(st_a[k], 1'b0));
      end
      drive(1'b1, 1'b1, 1'b1, (k == 3));
    end
    n_cmp++;
    if (bus_main.retired !== 16'd0) begin
      n_err++; $display("FAIL halt_exec_retired: got %0d want 0", bus_main.retired);
    end
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec(st_b[k], 1'b0)) begin
        n_err++; $display("FAIL halt_wb_vec[%0d]: got %h want %h", k, obs, exp_vec(st_b[k], 1'b0));
      end
      n_cmp++;
      if (bus_main.retired !== ((k >= 5) ? 16'd1 : 16'd0)) begin
        n_err++; $display("FAIL halt_wb_retired[%0d]: got %0d", k, bus_main.retired);
      end
      drive(1'b1, 1'b1, 1'b0, (k == 4));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_vec(3'd2, 1'b0)) begin
      n_err++; $display("FAIL pre_reset_decode: got %h want %h", obs, exp_vec(3'd2, 1'b0));
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== exp_vec(3'd0, 1'b0)) begin
      n_err++; $display("FAIL async_decode: got %h want %h", obs, exp_vec(3'd0, 1'b0));
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec(3'((k - 1) % 4 + 1), 1'b0)) begin
        n_err++; $display("FAIL resume1_vec[%0d]: got %h want %h", k, obs, exp_vec(3'((k - 1) % 4 + 1), 1'b0));
      end
    end
    n_cmp++;
    if (bus_main.retired !== 16'd1) begin
      n_err++; $display("FAIL resume1_retired: got %0d want 1", bus_main.retired);
    end
    // Drive into HALT with fault, then reset between clock edges.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    n_cmp++;
    if (obs !== exp_vec(3'd5, 1'b1)) begin
      n_err++; $display("FAIL pre_reset_halt: got %h want %h", obs, exp_vec(3'd5, 1'b1));
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== exp_vec(3'd0, 1'b0)) begin
      n_err++; $display("FAIL async_halt: got %h want %h", obs, exp_vec(3'd0, 1'b0));
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_vec(3'd1, 1'b0)) begin
      n_err++; $display("FAIL resume2_fetch: got %h want %h", obs, exp_vec(3'd1, 1'b0));
    end
  endtask

  task automatic test_saturate();
    int e;
    do_reset();
    bus_small.start     = 1'b1;
    bus_small.mem_ready = 1'b1;
    for (int k = 1; k <= 84; k++) begin
      @(negedge clk);
      e = (k - 1) / 4;
      if (e > 15) e = 15;
      n_cmp++;
      if (bus_small.retired !== 4'(e)) begin
        n_err++; $display("FAIL sat_retired[%0d]: got %0d want %0d", k, bus_small.retired, e);
      end
    end
    bus_small.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_halt();
    test_async_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
